// File: rtl/tm1638_key_events.sv
// tm1638_key_events: debounces the TM1638 key vector into a stable vector,
// one-clock press/release pulses and a show-ahead event FIFO.
module tm1638_key_events #(
  parameter int C_FCK        = 50_000_000,
  parameter int C_SAMPLE_HZ  = 1_000,
  parameter int C_STABLE_CNT = 4,
  parameter int C_FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] keys_raw,
  output logic [7:0] keys_stable,
  output logic [7:0] press_pulse,
  output logic [7:0] release_pulse,
  output logic       evt_valid,
  output logic [3:0] evt_data,
  input  logic       evt_ready,
  output logic       evt_overflow,
  input  logic       clr_overflow
);
  localparam int DIV = C_FCK / C_SAMPLE_HZ;
  localparam int DW  = $clog2(DIV);
  localparam int AW  = $clog2(C_FIFO_DEPTH);
  logic [DW-1:0] div_q, div_d;
  logic [7:0] ks1_q, ks1_d, ks_q, ks_d, stable_q, stable_d;
  logic [7:0] press_q, press_d, rel_q, rel_d, pend_p_q, pend_p_d, pend_r_q, pend_r_d;
  logic [7:0][3:0] cnt_q, cnt_d;
  logic [C_FIFO_DEPTH-1:0][3:0] mem_q, mem_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] fcnt_q, fcnt_d;
  logic ovf_q, ovf_d;
  logic tick, has_p, wr_req, full, pop, push;
  logic [2:0] sel_p, sel_r, sel_idx;
  logic [7:0] sel_mask;
  assign keys_stable   = stable_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign evt_overflow  = ovf_q;
  assign evt_valid     = fcnt_q != '0;
  assign evt_data      = mem_q[rp_q];
  always_comb begin
    tick     = div_q == DW'(DIV - 1);
    div_d    = tick ? '0 : div_q + DW'(1);
    ks1_d    = keys_raw;
    ks_d     = ks1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (tick)
      for (int i = 0; i < 8; i++)
        if (ks_q[i] == stable_q[i]) cnt_d[i] = '0;
        else if (cnt_q[i] == 4'(C_STABLE_CNT - 1)) begin
          stable_d[i] = ks_q[i];
          cnt_d[i]    = '0;
        end else cnt_d[i] = cnt_q[i] + 4'd1;
    press_d = stable_d & ~stable_q;
    rel_d   = ~stable_d & stable_q;
    // lowest-index pending bit of each kind; presses take priority
    sel_p = '0;
    sel_r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (pend_p_q[i]) sel_p = 3'(i);
      if (pend_r_q[i]) sel_r = 3'(i);
    end
    has_p    = |pend_p_q;
    wr_req   = has_p | (|pend_r_q);
    sel_idx  = has_p ? sel_p : sel_r;
    sel_mask = 8'd1 << sel_idx;
    pend_p_d = (pend_p_q & ~(has_p ? sel_mask : 8'h00)) | press_d;
    pend_r_d = (pend_r_q & ~(has_p ? 8'h00 : sel_mask)) | rel_d;
    full   = fcnt_q == (AW+1)'(C_FIFO_DEPTH);
    pop    = evt_valid & evt_ready;
    push   = wr_req & (~full | pop);
    mem_d  = mem_q;
    if (push) mem_d[wp_q] = {has_p, sel_idx};
    wp_d   = wp_q + AW'(push);
    rp_d   = rp_q + AW'(pop);
    fcnt_d = fcnt_q + (AW+1)'(push) - (AW+1)'(pop);
    ovf_d  = (wr_req & ~push) ? 1'b1 : clr_overflow ? 1'b0 : ovf_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      ks1_q    <= '0;
      ks_q     <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      press_q  <= '0;
      rel_q    <= '0;
      pend_p_q <= '0;
      pend_r_q <= '0;
      mem_q    <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      fcnt_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      div_q    <= div_d;
      ks1_q    <= ks1_d;
      ks_q     <= ks_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      pend_p_q <= pend_p_d;
      pend_r_q <= pend_r_d;
      mem_q    <= mem_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      fcnt_q   <= fcnt_d;
      ovf_q    <= ovf_d;
    end
  end
endmodule

// File: tb/tb_tm1638_key_events.sv
// tb_tm1638_key_events: directed plan steps plus random traffic, checked every
// cycle against a queue-based behavioural model of the key event path.
module tb_tm1638_key_events;
  localparam int DIV = 10;
  localparam int STB = 4;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst = 1'b1, evt_ready = 1'b0, clr_overflow = 1'b0;
  logic [7:0] keys_raw = '0;
  logic [7:0] keys_stable, press_pulse, release_pulse;
  logic evt_valid, evt_overflow;
  logic [3:0] evt_data;
  int n_cmp = 0, n_err = 0;
  int m_n, m_run[8];
  logic [7:0] m_s1, m_ks, m_stable, m_press, m_rel;
  logic m_ovf;
  logic [3:0] m_pend[$], m_fifo[$], obs[$];

  tm1638_key_events #(.C_FCK(1000), .C_SAMPLE_HZ(100), .C_STABLE_CNT(STB), .C_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .keys_raw(keys_raw), .keys_stable(keys_stable),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .evt_valid(evt_valid),
    .evt_data(evt_data), .evt_ready(evt_ready), .evt_overflow(evt_overflow),
    .clr_overflow(clr_overflow));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic model_step();
    logic [7:0] ns;
    logic [3:0] w;
    bit have_w, pop, full;
    if (rst) begin
      m_n = 0; m_s1 = '0; m_ks = '0; m_stable = '0; m_press = '0; m_rel = '0; m_ovf = 0;
      foreach (m_run[i]) m_run[i] = 0;
      m_pend.delete(); m_fifo.delete();
      return;
    end
    pop = m_fifo.size() > 0 && evt_ready;
    full = m_fifo.size() == DEPTH;
    have_w = m_pend.size() > 0;
    if (have_w) w = m_pend.pop_front();
    if (pop) void'(m_fifo.pop_front());
    if (have_w && (!full || pop)) m_fifo.push_back(w);
    if (have_w && full && !pop) m_ovf = 1;
    else if (clr_overflow) m_ovf = 0;
    ns = m_stable;
    if (m_n % DIV == DIV - 1)
      for (int i = 0; i < 8; i++) begin
        m_run[i] = (m_ks[i] == m_stable[i]) ? 0 : m_run[i] + 1;
        if (m_run[i] == STB) begin ns[i] = m_ks[i]; m_run[i] = 0; end
      end
    m_n++;
    m_press = ns & ~m_stable;
    m_rel = m_stable & ~ns;
    for (int i = 0; i < 8; i++) if (m_press[i]) m_pend.push_back({1'b1, 3'(i)});
    for (int i = 0; i < 8; i++) if (m_rel[i]) m_pend.push_back({1'b0, 3'(i)});
    m_stable = ns;
    m_ks = m_s1;
    m_s1 = keys_raw;
  endtask

  task automatic cyc(input logic [7:0] raw, input logic rdy, input logic clr, input logic r);
    keys_raw = raw; evt_ready = rdy; clr_overflow = clr; rst = r;
    if (!r && evt_valid && rdy) obs.push_back(evt_data);
    @(posedge clk);
    model_step();
    #1;
    chk("keys_stable", keys_stable, m_stable);
    chk("press_pulse", press_pulse, m_press);
    chk("release_pulse", release_pulse, m_rel);
    chk("evt_valid", evt_valid, m_fifo.size() > 0);
    chk("evt_overflow", evt_overflow, m_ovf);
    if (m_fifo.size() > 0) chk("evt_data", evt_data, m_fifo[0]);
  endtask

  task automatic hold(input logic [7:0] raw, input logic rdy, input int n);
    for (int k = 0; k < n; k++) cyc(raw, rdy, 0, 0);
  endtask

  initial begin
    int budget;
    cyc(8'h00, 0, 0, 1);
    cyc(8'h00, 0, 0, 1);
    hold(8'h00, 0, 200);
    chk("idle_stable", keys_stable, 8'h00);
    hold(8'h04, 0, 70);
    chk("press2_stable", keys_stable, 8'h04);
    chk("press2_valid", evt_valid, 1'b1);
    chk("press2_data", evt_data, 4'b1010);
    cyc(8'h04, 1, 0, 0);
    chk("press2_popped", evt_valid, 1'b0);
    hold(8'h00, 0, 70);
    chk("rel2_data", evt_data, 4'b0010);
    hold(8'h00, 1, 3);
    hold(8'h01, 1, 30);
    hold(8'h00, 1, 10);
    hold(8'h01, 1, 30);
    chk("glitch_no_change", keys_stable, 8'h00);
    hold(8'h01, 1, 15);
    chk("glitch_accepted", keys_stable, 8'h01);
    hold(8'h00, 1, 70);
    obs.delete();
    hold(8'h81, 1, 70);
    chk("dual_count", 8'(obs.size()), 8'd2);
    if (obs.size() == 2) begin
      chk("dual_first", obs[0], 4'b1000);
      chk("dual_second", obs[1], 4'b1111);
    end
    hold(8'h00, 1, 70);
    hold(8'h07, 0, 70);
    hold(8'h04, 0, 70);
    chk("ovf_set", evt_overflow, 1'b1);
    cyc(8'h04, 0, 1, 0);
    chk("ovf_cleared", evt_overflow, 1'b0);
    obs.delete();
    hold(8'h04, 1, 6);
    chk("drain_count", 8'(obs.size()), 8'd4);
    if (obs.size() == 4) begin
      chk("drain0", obs[0], 4'b1000);
      chk("drain1", obs[1], 4'b1001);
      chk("drain2", obs[2], 4'b1010);
      chk("drain3", obs[3], 4'b0000);
    end
    hold(8'h00, 0, 70);
    hold(8'h07, 0, 70);
    chk("full_valid", evt_valid, 1'b1);
    budget = 100;
    while (m_pend.size() == 0 && budget > 0) begin
      cyc(8'h0F, 0, 0, 0);
      budget--;
    end
    chk("pend_wait_expired", 8'(budget > 0), 8'd1);
    cyc(8'h0F, 1, 0, 0);
    chk("full_pop_push_no_ovf", evt_overflow, 1'b0);
    chk("full_pop_push_valid", evt_valid, 1'b1);
    cyc(8'h0F, 0, 0, 1);
    chk("rst_valid", evt_valid, 1'b0);
    chk("rst_stable", keys_stable, 8'h00);
    for (int k = 0; k < 120; k++) begin
      logic [7:0] raw;
      int n;
      raw = 8'($urandom);
      n = $urandom_range(1, 60);
      for (int j = 0; j < n; j++)
        cyc(raw, $urandom_range(0, 3) != 0, $urandom_range(0, 20) == 0, $urandom_range(0, 500) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
